// File: rtl/mmss_timer_ctrl.sv
// mmss_timer_ctrl: minutes:seconds stopwatch controller.
//   Includes a 1 s prescaler, a mod-10/mod-6 digit cascade and a
//   start/stop/set-mode FSM driven by debounced single-cycle buttons.
// Optional feature macro: MMSS_BLINK_EN. When it is defined, the selected
//   field blinks in set mode through blank_min/blank_sec.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   btn_start           start/stop pulse (highest priority)
//   btn_mode            cycle IDLE -> SET_MIN -> SET_SEC -> IDLE
//   btn_inc             increment the selected field in set mode
//   sec_lo/sec_hi       seconds digits (0-9 / 0-5)
//   min_lo/min_hi       minutes digits (0-9 / 0-5)
//   state               0 IDLE, 1 RUN, 2 SET_MIN, 3 SET_SEC
//   tick                combinational, high on the cycle the time advances
//   rollover            registered pulse after the 59:59 -> 00:00 advance
//   blank_min/blank_sec blink blanking (MMSS_BLINK_EN only)
module mmss_timer_ctrl #(
   parameter int unsigned TICK_DIV = 100000000,
   parameter int unsigned DIV_W    = 27
`ifdef MMSS_BLINK_EN
   ,
   parameter int unsigned BLINK_HALF = 50000000
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [3:0] sec_lo,
   output logic [3:0] sec_hi,
   output logic [3:0] min_lo,
   output logic [3:0] min_hi,
   output logic [1:0] state,
   output logic       tick,
   output logic       rollover
`ifdef MMSS_BLINK_EN
   ,
   output logic       blank_min,
   output logic       blank_sec
`endif
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_SET_MIN = 2'd2,
      S_SET_SEC = 2'd3
   } state_t;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   state_t           st;
   state_t           st_next;
   logic [DIV_W-1:0] div;
   logic             start_ev;
   logic             mode_ev;
   logic             inc_ev;
   logic [3:0]       sec_lo_n;
   logic [3:0]       sec_hi_n;
   logic [3:0]       min_lo_n;
   logic [3:0]       min_hi_n;
   logic             carry_out;

   // Strict button priority: only the highest-priority pulse acts.
   assign start_ev = btn_start;
   assign mode_ev  = btn_mode & ~btn_start;
   assign inc_ev   = btn_inc & ~btn_start & ~btn_mode;

   assign state = st;

   // State register
   always_ff @(posedge clk) begin
      if (rst) st <= S_IDLE;
      else     st <= st_next;
   end

   // Next-state logic
   always_comb begin
      st_next = st;
      case (st)
         S_IDLE: begin
            if (start_ev)     st_next = S_RUN;
            else if (mode_ev) st_next = S_SET_MIN;
         end
         S_RUN: begin
            if (start_ev) st_next = S_IDLE;
         end
         S_SET_MIN: begin
            if (mode_ev) st_next = S_SET_SEC;
         end
         S_SET_SEC: begin
            if (mode_ev) st_next = S_IDLE;
         end
         default: st_next = S_IDLE;
      endcase
   end

   // Prescaler: free-runs only while staying in RUN, so a stop or a fresh
   // start always restarts the second from zero.
   always_ff @(posedge clk) begin
      if (rst)                                   div <= '0;
      else if (st == S_RUN && st_next == S_RUN)  div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      else                                       div <= '0;
   end

`ifdef MMSS_BLINK_EN
   localparam int unsigned      BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

   logic [BLINK_W-1:0] blink_cnt;
   logic               phase;
   logic               set_next;

   assign set_next = (st_next == S_SET_MIN) || (st_next == S_SET_SEC);

   // Blink timer restarts on set-state entry and on each edit so the field
   // is shown solidly right after it changes.
   always_ff @(posedge clk) begin
      if (rst || !set_next) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (st_next != st || inc_ev) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + BLINK_W'(1);
      end
   end
`endif

   // Output logic
   always_comb begin
      tick = 1'b0;
      // A coincident stop wins over the pending tick.
      if (st == S_RUN && div == DIV_LAST && !start_ev) tick = 1'b1;
`ifdef MMSS_BLINK_EN
      blank_min = (st == S_SET_MIN) && phase;
      blank_sec = (st == S_SET_SEC) && phase;
`endif
   end

   // Digit next-values: run cascade or set-mode field increment.
   always_comb begin
      sec_lo_n  = sec_lo;
      sec_hi_n  = sec_hi;
      min_lo_n  = min_lo;
      min_hi_n  = min_hi;
      carry_out = 1'b0;
      if (tick) begin
         sec_lo_n = (sec_lo == 4'd9) ? 4'd0 : sec_lo + 4'd1;
         if (sec_lo == 4'd9) begin
            sec_hi_n = (sec_hi == 4'd5) ? 4'd0 : sec_hi + 4'd1;
            if (sec_hi == 4'd5) begin
               min_lo_n = (min_lo == 4'd9) ? 4'd0 : min_lo + 4'd1;
               if (min_lo == 4'd9) begin
                  min_hi_n  = (min_hi == 4'd5) ? 4'd0 : min_hi + 4'd1;
                  carry_out = (min_hi == 4'd5);
               end
            end
         end
      end else if (inc_ev && st == S_SET_MIN) begin
         min_lo_n = (min_lo == 4'd9) ? 4'd0 : min_lo + 4'd1;
         if (min_lo == 4'd9) min_hi_n = (min_hi == 4'd5) ? 4'd0 : min_hi + 4'd1;
      end else if (inc_ev && st == S_SET_SEC) begin
         // Seconds wrap within the field; minutes are untouched.
         sec_lo_n = (sec_lo == 4'd9) ? 4'd0 : sec_lo + 4'd1;
         if (sec_lo == 4'd9) sec_hi_n = (sec_hi == 4'd5) ? 4'd0 : sec_hi + 4'd1;
      end
   end

   // Digit and rollover registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sec_lo   <= 4'd0;
         sec_hi   <= 4'd0;
         min_lo   <= 4'd0;
         min_hi   <= 4'd0;
         rollover <= 1'b0;
      end else begin
         sec_lo   <= sec_lo_n;
         sec_hi   <= sec_hi_n;
         min_lo   <= min_lo_n;
         min_hi   <= min_hi_n;
         rollover <= carry_out;
      end
   end

endmodule

// File: tb/tb_mmss_timer_ctrl.sv
// Self-checking bench for mmss_timer_ctrl with TICK_DIV=4 (BLINK_HALF=3
// when MMSS_BLINK_EN is defined).
module tb_mmss_timer_ctrl;
   localparam int unsigned TICK_DIV = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_start;
   logic       btn_mode;
   logic       btn_inc;
   logic [3:0] sec_lo;
   logic [3:0] sec_hi;
   logic [3:0] min_lo;
   logic [3:0] min_hi;
   logic [1:0] state;
   logic       tick;
   logic       rollover;
`ifdef MMSS_BLINK_EN
   logic       blank_min;
   logic       blank_sec;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [15:0] tm;
      logic [1:0]  st;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   mmss_timer_ctrl #(
      .TICK_DIV (TICK_DIV),
      .DIV_W    (3)
`ifdef MMSS_BLINK_EN
      ,
      .BLINK_HALF (3)
`endif
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_start (btn_start),
      .btn_mode  (btn_mode),
      .btn_inc   (btn_inc),
      .sec_lo    (sec_lo),
      .sec_hi    (sec_hi),
      .min_lo    (min_lo),
      .min_hi    (min_hi),
      .state     (state),
      .tick      (tick),
      .rollover  (rollover)
`ifdef MMSS_BLINK_EN
      ,
      .blank_min (blank_min),
      .blank_sec (blank_sec)
`endif
   );

   function automatic logic [15:0] cur_tm();
      return {min_hi, min_lo, sec_hi, sec_lo};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic s, input logic m, input logic i);
      btn_start = s;
      btn_mode  = m;
      btn_inc   = i;
      step();
      btn_start = 1'b0;
      btn_mode  = 1'b0;
      btn_inc   = 1'b0;
   endtask

   task automatic inc_n(input int n);
      repeat (n) pulse(1'b0, 1'b0, 1'b1);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_sb(input logic [15:0] tm, input logic [1:0] st);
      exp_t e;
      e.tm = tm;
      e.st = st;
      sb_q.push_back(e);
   endtask

   task automatic check_sb(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $error("FAIL %s: observed %0h expected scoreboard entry (queue empty)", tag, cur_tm());
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_time"}, 32'(cur_tm()), 32'(e.tm));
         chk({tag, "_state"}, 32'(state), 32'(e.st));
      end
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      while (tick !== 1'b1 && n < 20) begin
         step();
         n++;
      end
   endtask

   initial begin
      int n;
      int ticks;
      rst       = 1'b1;
      btn_start = 1'b0;
      btn_mode  = 1'b0;
      btn_inc   = 1'b0;
      #1;
      step();
      step();

      // Reset state
      expect_sb(16'h0000, 2'd0);
      check_sb("reset");
      chk("reset_tick", 32'(tick), 32'd0);
      chk("reset_rollover", 32'(rollover), 32'd0);
      rst = 1'b0;

      // Start, first tick latency, ten ticks
      expect_sb(16'h0000, 2'd1);
      pulse(1'b1, 1'b0, 1'b0);
      check_sb("run_entry");
      wait_tick(n);
      chk("first_tick_edge", 32'(n + 1), 32'(TICK_DIV));
      chk("pre_tick_time", 32'(cur_tm()), 32'h0000);
      step();
      chk("one_tick", 32'(cur_tm()), 32'h0001);
      ticks = 0;
      repeat (36) begin
         if (tick === 1'b1) ticks++;
         step();
      end
      chk("tick_count", 32'(ticks), 32'd9);
      expect_sb(16'h0010, 2'd1);
      check_sb("ten_ticks");

      // Stop coincident with a pending tick
      step();
      step();
      step();
      chk("tick_before_stop", 32'(tick), 32'd1);
      btn_start = 1'b1;
      #1;
      chk("tick_suppressed", 32'(tick), 32'd0);
      expect_sb(16'h0010, 2'd0);
      step();
      btn_start = 1'b0;
      check_sb("stop_on_tick");

      // Start+mode together, then mode/inc ignored in RUN
      expect_sb(16'h0010, 2'd1);
      pulse(1'b1, 1'b1, 1'b0);
      check_sb("start_and_mode");
      pulse(1'b0, 1'b1, 1'b0);
      pulse(1'b0, 1'b0, 1'b1);
      expect_sb(16'h0010, 2'd1);
      check_sb("run_ignores_mode_inc");
      expect_sb(16'h0010, 2'd0);
      pulse(1'b1, 1'b0, 1'b0);
      check_sb("stop");

      // Preload 59:58 and check minute wrap in SET_MIN
      expect_sb(16'h5910, 2'd2);
      pulse(1'b0, 1'b1, 1'b0);
      inc_n(59);
      check_sb("set_min_59");
      expect_sb(16'h0010, 2'd2);
      inc_n(1);
      check_sb("min_wrap");
      inc_n(59);
      pulse(1'b0, 1'b1, 1'b0);
      expect_sb(16'h5958, 2'd3);
      inc_n(48);
      check_sb("set_sec_58");
      pulse(1'b0, 1'b1, 1'b0);
      expect_sb(16'h5958, 2'd1);
      pulse(1'b1, 1'b0, 1'b0);
      check_sb("run_from_5958");
      repeat (4) step();
      expect_sb(16'h5959, 2'd1);
      check_sb("at_5959");
      chk("no_rollover_5959", 32'(rollover), 32'd0);
      repeat (3) step();
      chk("tick_at_wrap", 32'(tick), 32'd1);
      step();
      expect_sb(16'h0000, 2'd1);
      check_sb("wrap_0000");
      chk("rollover_high", 32'(rollover), 32'd1);
      step();
      chk("rollover_one_cycle", 32'(rollover), 32'd0);

      // Reset mid-RUN at 12:34
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      inc_n(12);
      pulse(1'b0, 1'b1, 1'b0);
      inc_n(34);
      expect_sb(16'h1234, 2'd0);
      pulse(1'b0, 1'b1, 1'b0);
      check_sb("preload_1234");
      pulse(1'b1, 1'b0, 1'b0);
      step();
      expect_sb(16'h1234, 2'd1);
      check_sb("run_1234");
      rst = 1'b1;
      expect_sb(16'h0000, 2'd0);
      step();
      rst = 1'b0;
      check_sb("rst_mid_run");
      chk("rst_div", 32'(dut.div), 32'd0);
      pulse(1'b1, 1'b0, 1'b0);
      wait_tick(n);
      chk("restart_tick_edge", 32'(n + 1), 32'(TICK_DIV));
      expect_sb(16'h0000, 2'd0);
      pulse(1'b1, 1'b0, 1'b0);
      check_sb("stop_after_restart");

      // SET_SEC wraps 00:59 -> 00:00 without carry into minutes
      pulse(1'b0, 1'b1, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      expect_sb(16'h0059, 2'd3);
      inc_n(59);
      check_sb("set_sec_59");
      expect_sb(16'h0000, 2'd3);
      inc_n(1);
      check_sb("sec_wrap_no_carry");
      rst = 1'b1;
      expect_sb(16'h0000, 2'd0);
      step();
      rst = 1'b0;
      check_sb("rst_mid_set");

`ifdef MMSS_BLINK_EN
      // Blink phase in SET_MIN and restart after an edit
      pulse(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) begin
         chk("blank_min_run", 32'(blank_min), 32'((k / 3) % 2));
         chk("blank_sec_in_min", 32'(blank_sec), 32'd0);
         step();
      end
      inc_n(1);
      for (int j = 0; j < 5; j++) begin
         chk("blank_min_after_inc", 32'(blank_min), 32'((j / 3) % 2));
         step();
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
